// File: rtl/diff_freq_serial_out_unit.sv
// Two-channel serial pattern generator fed by a UART byte stream.
// Packets of PACK_NUM bytes select a channel and start/stop its pattern.
module diff_freq_serial_out_unit #(
  parameter int       DATA_BIT   = 8,
  parameter int       PACK_NUM   = 3,
  parameter int       LOW_DIV    = 20,
  parameter int       HIGH_DIV   = 10,
  parameter logic     IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic                i_rx_done_tick,
  output logic                o_serial_out0,
  output logic                o_serial_out1,
  output logic                o_bit_tick,
  output logic                o_done_tick
);

  localparam int MAXDIV = (LOW_DIV > HIGH_DIV) ? LOW_DIV : HIGH_DIV;
  localparam int CW = $clog2(MAXDIV);
  localparam int IW = $clog2(DATA_BIT);
  localparam int BW = (PACK_NUM > 1) ? $clog2(PACK_NUM) : 1;

  typedef enum logic {IDLE, RUN} ch_state_t;

  logic [DATA_BIT-1:0] slot [PACK_NUM];
  logic [BW-1:0]       byte_cnt;
  logic                cmd_valid;

  logic [DATA_BIT-1:0] ctrl;
  logic                cmd_start;
  logic                cmd_stop;
  logic                cmd_mode;
  logic [3:0]          cmd_chan;
  logic                unused_ctrl;

  ch_state_t           st     [2];
  ch_state_t           st_n   [2];
  logic [IW-1:0]       idx    [2];
  logic [IW-1:0]       idx_n  [2];
  logic [CW-1:0]       cnt    [2];
  logic [CW-1:0]       cnt_n  [2];
  logic [DATA_BIT-1:0] opat   [2];
  logic [DATA_BIT-1:0] opat_n [2];
  logic [DATA_BIT-1:0] fpat   [2];
  logic [DATA_BIT-1:0] fpat_n [2];
  logic [1:0]          mode_r;
  logic [1:0]          mode_n;
  logic [1:0]          ser;
  logic [1:0]          ser_n;
  logic [1:0]          btk;
  logic [1:0]          btk_n;
  logic [1:0]          dtk;
  logic [1:0]          dtk_n;

  // Cycle count of the last cycle of a bit at the given speed.
  function automatic logic [CW-1:0] last_cnt(input logic f);
    last_cnt = f ? CW'(HIGH_DIV - 1) : CW'(LOW_DIV - 1);
  endfunction

  assign ctrl        = slot[PACK_NUM-1];
  assign cmd_start   = ctrl[0];
  assign cmd_stop    = ctrl[1];
  assign cmd_mode    = ctrl[2];
  assign cmd_chan    = ctrl[6:3];
  assign unused_ctrl = ^ctrl[DATA_BIT-1:7];

  // Collect bytes into slots; flag a complete packet one cycle later.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      byte_cnt  <= '0;
      cmd_valid <= 1'b0;
      for (int i = 0; i < PACK_NUM; i++) slot[i] <= '0;
    end else begin
      cmd_valid <= 1'b0;
      if (i_rx_done_tick) begin
        slot[byte_cnt] <= i_data;
        if (byte_cnt == BW'(PACK_NUM - 1)) begin
          byte_cnt  <= '0;
          cmd_valid <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + BW'(1);
        end
      end
    end
  end

  // Per-channel next state: advance the running pattern, then apply commands.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      st_n[c]   = st[c];
      idx_n[c]  = idx[c];
      cnt_n[c]  = cnt[c];
      opat_n[c] = opat[c];
      fpat_n[c] = fpat[c];
      mode_n[c] = mode_r[c];
      if (st[c] == RUN) begin
        if (cnt[c] == last_cnt(fpat[c][idx[c]])) begin
          cnt_n[c] = '0;
          if (idx[c] == IW'(DATA_BIT - 1)) begin
            idx_n[c] = '0;
            if (!mode_r[c]) st_n[c] = IDLE;
          end else begin
            idx_n[c] = idx[c] + IW'(1);
          end
        end else begin
          cnt_n[c] = cnt[c] + CW'(1);
        end
      end
      if (cmd_valid && cmd_chan == 4'(c)) begin
        if (cmd_stop) begin
          st_n[c] = IDLE;
        end else if (cmd_start) begin
          st_n[c]   = RUN;
          idx_n[c]  = '0;
          cnt_n[c]  = '0;
          opat_n[c] = slot[0];
          fpat_n[c] = slot[1];
          mode_n[c] = cmd_mode;
        end
      end
      ser_n[c] = (st_n[c] == RUN) ? opat_n[c][idx_n[c]] : IDLE_LEVEL;
      btk_n[c] = (st_n[c] == RUN) &&
                 (cnt_n[c] == last_cnt(fpat_n[c][idx_n[c]]));
      dtk_n[c] = btk_n[c] && (idx_n[c] == IW'(DATA_BIT - 1));
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 2; c++) begin
        st[c]   <= IDLE;
        idx[c]  <= '0;
        cnt[c]  <= '0;
        opat[c] <= '0;
        fpat[c] <= '0;
      end
      mode_r <= '0;
      ser    <= {2{IDLE_LEVEL}};
      btk    <= '0;
      dtk    <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st[c]   <= st_n[c];
        idx[c]  <= idx_n[c];
        cnt[c]  <= cnt_n[c];
        opat[c] <= opat_n[c];
        fpat[c] <= fpat_n[c];
      end
      mode_r <= mode_n;
      ser    <= ser_n;
      btk    <= btk_n;
      dtk    <= dtk_n;
    end
  end

  assign o_serial_out0 = ser[0];
  assign o_serial_out1 = ser[1];
  assign o_bit_tick    = |btk;
  assign o_done_tick   = |dtk;

endmodule

// File: tb/tb_diff_freq_serial_out_unit.sv
// Directed bench for diff_freq_serial_out_unit.
// Outputs are sampled on the falling edge.
module tb_diff_freq_serial_out_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_rx_done_tick;
  logic       o_serial_out0;
  logic       o_serial_out1;
  logic       o_bit_tick;
  logic       o_done_tick;

  int total = 0;
  int bad   = 0;

  diff_freq_serial_out_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_data         (i_data),
    .i_rx_done_tick (i_rx_done_tick),
    .o_serial_out0  (o_serial_out0),
    .o_serial_out1  (o_serial_out1),
    .o_bit_tick     (o_bit_tick),
    .o_done_tick    (o_done_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  // One byte strobe per cycle; called and returns on a falling edge.
  task automatic send(input logic [7:0] b);
    i_data         = b;
    i_rx_done_tick = 1'b1;
    @(negedge clk);
    i_rx_done_tick = 1'b0;
    i_data         = 8'h00;
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_out0", o_serial_out0, 1'b0);
      chk("idle_out1", o_serial_out1, 1'b0);
      chk("idle_bit", o_bit_tick, 1'b0);
      chk("idle_done", o_done_tick, 1'b0);
      @(negedge clk);
    end
  endtask

  // Checks nbits bit periods starting at the first cycle of bit 0.
  task automatic expect_pass(input int ch, input logic [7:0] op,
                             input logic [7:0] fp, input int nbits);
    int  len;
    logic last;
    for (int b = 0; b < nbits; b++) begin
      len = fp[b] ? 10 : 20;
      for (int k = 0; k < len; k++) begin
        last = (k == len - 1);
        chk("ser", (ch == 0) ? o_serial_out0 : o_serial_out1, op[b]);
        chk("other", (ch == 0) ? o_serial_out1 : o_serial_out0, 1'b0);
        chk("bit_tick", o_bit_tick, last);
        chk("done_tick", o_done_tick, last && (b == 7));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b1;
    i_data         = 8'h00;
    i_rx_done_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    idle_check(3);

    // ch0 one-shot, alternating pattern and speed
    send(8'h55); send(8'h55); send(8'h01);
    @(negedge clk);
    expect_pass(0, 8'h55, 8'h55, 8);
    idle_check(5);

    // channel 2 packet during a ch0 run is ignored
    send(8'h55); send(8'h55); send(8'h01);
    @(negedge clk);
    fork
      expect_pass(0, 8'h55, 8'h55, 8);
      begin
        repeat (20) @(negedge clk);
        send(8'h55); send(8'h55); send(8'h11);
      end
    join
    idle_check(5);

    // ch1 repeat, two full passes, then stop
    send(8'hF0); send(8'h00); send(8'h0D);
    @(negedge clk);
    expect_pass(1, 8'hF0, 8'h00, 8);
    expect_pass(1, 8'hF0, 8'h00, 8);
    expect_pass(1, 8'hF0, 8'h00, 3);
    send(8'h00); send(8'h00); send(8'h0A);
    @(negedge clk);
    idle_check(200);

    // restart of a busy ch0 with a new pattern
    send(8'hFF); send(8'h00); send(8'h01);
    @(negedge clk);
    expect_pass(0, 8'hFF, 8'h00, 3);
    send(8'h00); send(8'h00); send(8'h01);
    @(negedge clk);
    expect_pass(0, 8'h00, 8'h00, 8);
    idle_check(5);

    // partial packet discarded by reset
    send(8'hFF); send(8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    idle_check(2);
    send(8'h03); send(8'h00); send(8'h01);
    @(negedge clk);
    expect_pass(0, 8'h03, 8'h00, 8);
    idle_check(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diff_freq_serial_out_unit.md
Name: diff_freq_serial_out_unit

Overview:
- Packet-driven two-channel serial pattern generator. It sits behind a UART receiver and consumes its byte stream (i_data qualified by i_rx_done_tick).
- Every PACK_NUM bytes form one command packet: output pattern, per-bit speed pattern, control byte.
- The addressed channel shifts its pattern out LSB-first. Each bit is held for a low-speed or high-speed period.
- One-shot and repeat modes are supported, with bit and done ticks.

Parameters:
- DATA_BIT, 8: width of each received byte and of each pattern.
- PACK_NUM, 3: bytes per packet (byte0 output pattern, byte1 frequency pattern, byte2 control).
- LOW_DIV, 20: clock cycles per bit when the frequency bit = 0 (low speed).
- HIGH_DIV, 10: clock cycles per bit when the frequency bit = 1 (high speed).
- IDLE_LEVEL, 1'b0: serial output level when a channel is idle.

Ports:
- clk  input  1  system clock; single clock domain, all logic on rising edge.
- rst_n  input  1  reset; synchronous and active-high (asserted = 1).
- i_data  input  DATA_BIT  received byte from the UART.
- i_rx_done_tick  input  1  one-cycle strobe; i_data is valid this cycle.
- o_serial_out0  output  1  channel 0 serial output, idle low.
- o_serial_out1  output  1  channel 1 serial output, idle low.
- o_bit_tick  output  1  one-cycle pulse at the end of every bit period on either channel.
- o_done_tick  output  1  one-cycle pulse when either channel completes a full DATA_BIT-bit pass.

Behaviour:
- Reset: both outputs = IDLE_LEVEL, ticks = 0, byte counter = 0, both channels idle.
- Packet assembly:
  - Each i_rx_done_tick stores i_data into slot[byte_cnt] and increments byte_cnt.
  - When slot PACK_NUM-1 is stored, byte_cnt wraps to 0 and a command-valid flag is registered, one cycle after the last-byte strobe.
  - There is no timeout; a partial packet waits indefinitely.
- Control byte decode:
  - bit0 START, bit1 STOP, bit2 MODE (0 = one-shot, 1 = repeat), bits[6:3] channel number, bit7 ignored.
  - Channel numbers 0 and 1 are valid. Any other channel number causes the whole packet to be discarded, with no effect on either channel.
  - STOP=1: the addressed channel returns to idle on the command-valid cycle and its output goes to IDLE_LEVEL. STOP has priority over START.
  - STOP=0 and START=1: the addressed channel loads the out/freq patterns and MODE, and starts. This applies even if the channel is busy, in which case it restarts immediately with the new patterns.
  - START=0 and STOP=0: no effect.
- Channel FSM, per channel: IDLE -> RUN on start.
  - In RUN, the channel holds out_pat[idx] on its output for N cycles, where N = HIGH_DIV if freq_pat[idx] = 1, else LOW_DIV. idx starts at 0.
  - On the last cycle of each bit the channel pulses bit_tick and increments idx.
  - After bit DATA_BIT-1 it pulses done_tick together with the final bit_tick.
    - One-shot: go to IDLE and drive IDLE_LEVEL from the next cycle.
    - Repeat: idx wraps to 0 and the pass repeats until a STOP command.
- Output timing: bit 0 appears on the output the cycle after command-valid, i.e. 2 clocks after the last-byte strobe.
- Output registers: outputs and ticks are registered; o_bit_tick and o_done_tick are the OR of both channels' ticks.
- Concurrency: the channels run independently and concurrently. A new packet may be received while either channel runs.
- Reset mid-operation: a reset in the middle of a packet or a run discards everything and returns to the reset state.

Test Plan:
- Reset with rst_n=1 for 2 cycles -> both outputs 0, no ticks, byte counter 0.
- Bytes 0x55, 0x55, 0x01 (ch0, one-shot, start) -> o_serial_out0 sequence is:
  - 1 for 10 cycles, 0 for 20, 1 for 10, 0 for 20, 1 for 10, 0 for 20, 1 for 10, 0 for 20 (120 cycles total);
  - 8 o_bit_ticks; o_done_tick coincides with the 8th; output idle low afterwards; o_serial_out1 stays 0.
- Bytes 0x55, 0x55, 0x11 (channel 2) -> ignored: no output change, no ticks; a running ch0 is unaffected.
- Bytes 0xF0, 0x00, 0x0D (ch1, repeat, start) -> o_serial_out1 is 0 for 80 cycles then 1 for 80, repeating; o_done_tick every 160 cycles.
  - Then bytes 0x00, 0x00, 0x0A (ch1, stop) -> output 0 and no ticks from the command-valid cycle onward.
- Start ch0 with pattern 0xFF; after 3 bits send a new start with pattern 0x00 -> restart at bit 0 with output 0, and no done tick from the first run.
- Two bytes of a packet, then a reset, then a full packet -> only the full packet executes; the stale bytes are discarded.
